uart_cmd_decoder: RTL

Byte-stream command controller that sits directly behind the UART receiver in the configurable blinky design. It frames incoming bytes into 5-byte write commands, checks them, and commits 16-bit values into a small bank of configuration registers that drive the blink logic. It also reports framing, address and inter-byte timeout errors.

---
 rtl/uart_cmd_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// Frames the UART byte stream into 5-byte write commands (SYNC, ADDR, DHI, DLO, CSUM)
// and commits 16-bit values into the configuration register bank driving the blinky logic.
module uart_cmd_decoder #(
    parameter int         NUM_REGS  = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 100000
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_data,
    input  logic                     i_data_valid,
    output logic [16*NUM_REGS-1:0]   o_regs,
    output logic                     o_wr_en,
    output logic [7:0]               o_wr_addr,
    output logic [15:0]              o_wr_data,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic                     o_busy
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [8:0]       REG_LIMIT = 9'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_valid_prev;
    logic             w_byte;
    logic [7:0]       r_addr;
    logic [7:0]       r_dhi;
    logic [7:0]       r_dlo;
    logic [CNT_W-1:0] r_timer;
    logic             w_timeout;
    logic             w_csum_ok;
    logic             w_addr_ok;
    logic             w_commit;
    logic             w_err;
    logic [1:0]       w_err_code;

    // The receiver's valid is a level; only its rising edge counts as a new byte.
    assign w_byte    = i_data_valid & ~r_valid_prev;
    assign w_timeout = (r_state != S_IDLE) && !w_byte && (r_timer == CNT_LAST);
    assign w_csum_ok = (i_data == (r_addr ^ r_dhi ^ r_dlo));
    assign w_addr_ok = ({1'b0, r_addr} < REG_LIMIT);
    assign o_busy    = (r_state != S_IDLE);

    // Reset to 1 so a valid already high when reset releases is not taken as a byte.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_valid_prev <= 1'b1;
        end else begin
            r_valid_prev <= i_data_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_err_code   = 2'd0;
        if (w_timeout) begin
            w_next_state = S_IDLE;
            w_err        = 1'b1;
            w_err_code   = 2'd3;
        end else if (w_byte) begin
            case (r_state)
                S_IDLE: begin
                    if (i_data == SYNC_BYTE) begin
                        w_next_state = S_ADDR;
                    end
                end
                S_ADDR:  w_next_state = S_DHI;
                S_DHI:   w_next_state = S_DLO;
                S_DLO:   w_next_state = S_CSUM;
                S_CSUM: begin
                    w_next_state = S_IDLE;
                    // A corrupted frame may also carry a corrupted address, so checksum wins.
                    if (!w_csum_ok) begin
                        w_err      = 1'b1;
                        w_err_code = 2'd1;
                    end else if (!w_addr_ok) begin
                        w_err      = 1'b1;
                        w_err_code = 2'd2;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_addr <= 8'd0;
            r_dhi  <= 8'd0;
            r_dlo  <= 8'd0;
        end else if (w_byte) begin
            case (r_state)
                S_ADDR:  r_addr <= i_data;
                S_DHI:   r_dhi  <= i_data;
                S_DLO:   r_dlo  <= i_data;
                default: ;
            endcase
        end
    end

    // Inter-byte watchdog: runs only while a frame is open.
    always_ff @(posedge clk) begin
        if (i_reset || (r_state == S_IDLE) || w_byte) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_wr_en    <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
            o_wr_addr  <= 8'd0;
            o_wr_data  <= 16'd0;
        end else begin
            o_wr_en <= w_commit;
            o_err   <= w_err;
            if (w_err) begin
                o_err_code <= w_err_code;
            end
            if (w_commit) begin
                o_wr_addr <= r_addr;
                o_wr_data <= {r_dhi, r_dlo};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_regs <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (r_addr == 8'(k)) begin
                    o_regs[16*k +: 16] <= {r_dhi, r_dlo};
                end
            end
        end
    end

endmodule
